dmem_arbiter: RTL

Two-port arbiter for the single-port data memory (dmem). Shares dmem between the processor's data port (port P: lw/sw traffic) and a loader/debug port (port L: memory initialisation and inspection). Processor has fixed priority, with a starvation counter guaranteeing the loader periodic access. Sits between `processor` and `dmem` in `skeleton`. Drives dmem `address`, `data` and `wren`, and registers read data back to the granted port.

---
 rtl/dmem_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port dmem between processor (P) and loader (L).
// P has fixed priority; a starvation counter forces a one-cycle L slot.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p_req,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    input  logic              p_wren,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              l_req,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    input  logic              l_wren,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic [ADDR_W-1:0] address_dmem,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic [DATA_W-1:0] q_dmem,
    output logic              force_active
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic [3:0]        cnt_inc;
    logic              force_q, force_d;
    logic              p_rvalid_q, p_rvalid_d;
    logic              l_rvalid_q, l_rvalid_d;
    logic [DATA_W-1:0] p_rdata_q, l_rdata_q;

    // Grants are qualified by reset so nothing reaches dmem while in reset.
    always_comb begin
        p_gnt = 1'b0;
        l_gnt = 1'b0;
        if (reset) begin
            if (force_q && l_req) begin
                l_gnt = 1'b1;
            end else if (p_req) begin
                p_gnt = 1'b1;
            end else begin
                l_gnt = l_req;
            end
        end
    end

    always_comb begin
        address_dmem = '0;
        data         = '0;
        wren         = 1'b0;
        if (p_gnt) begin
            address_dmem = p_addr;
            data         = p_wdata;
            wren         = p_wren;
        end else if (l_gnt) begin
            address_dmem = l_addr;
            data         = l_wdata;
            wren         = l_wren;
        end
    end

    always_comb begin
        cnt_inc      = starve_cnt_q + 4'd1;
        starve_cnt_d = 4'd0;
        force_d      = 1'b0;
        if (l_req && !l_gnt) begin
            if (cnt_inc == LIMIT) begin
                force_d = 1'b1;
            end else begin
                starve_cnt_d = cnt_inc;
            end
        end
        p_rvalid_d = p_gnt && !p_wren;
        l_rvalid_d = l_gnt && !l_wren;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= 4'd0;
            force_q      <= 1'b0;
            p_rvalid_q   <= 1'b0;
            l_rvalid_q   <= 1'b0;
            p_rdata_q    <= '0;
            l_rdata_q    <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            force_q      <= force_d;
            p_rvalid_q   <= p_rvalid_d;
            l_rvalid_q   <= l_rvalid_d;
            if (p_rvalid_d) begin
                p_rdata_q <= q_dmem;
            end
            if (l_rvalid_d) begin
                l_rdata_q <= q_dmem;
            end
        end
    end

    assign p_rvalid     = p_rvalid_q;
    assign l_rvalid     = l_rvalid_q;
    assign p_rdata      = p_rdata_q;
    assign l_rdata      = l_rdata_q;
    assign force_active = force_q;

endmodule
